// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// MULTDIV_BOOTH4_EN selects the radix-4 Booth multiplier (16 iterations).
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  localparam int DIV_ITERS = 32;
`ifdef MULTDIV_BOOTH4_EN
  localparam int MULT_ITERS = 16;
`else
  localparam int MULT_ITERS = 32;
`endif

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/multdiv_div_step.sv
// One restoring-division iteration on magnitudes: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep or restore.
module multdiv_div_step
  import multdiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_quo,
  input  logic [DATA_W-1:0] i_dvsr,
  output logic [DATA_W-1:0] o_rem,
  output logic [DATA_W-1:0] o_quo
);

  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_trial;

  // Partial remainder stays below the divisor magnitude, so bit DATA_W of the
  // shifted value is zero and bit DATA_W of the trial is a clean borrow flag.
  assign w_shift = {i_rem, i_quo[DATA_W-1]};
  assign w_trial = w_shift - {1'b0, i_dvsr};

  always_comb begin
    o_rem = w_shift[DATA_W-1:0];
    o_quo = {i_quo[DATA_W-2:0], 1'b0};
    if (!w_trial[DATA_W]) begin
      o_rem = w_trial[DATA_W-1:0];
      o_quo = {i_quo[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply/divide responder for ctrl_MULT/ctrl_DIV.
// Define MULTDIV_BOOTH4_EN for the radix-4 Booth multiplier (17-cycle multiply).
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  input  logic              ctrl_MULT,
  input  logic              ctrl_DIV,
  output logic [DATA_W-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY
);

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_ITERS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_ITERS - 1);

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] apply_sign64(input logic [2*DATA_W-1:0] p,
                                                       input logic neg);
    return neg ? (~p + 1'b1) : p;
  endfunction

  // Signed overflow: the upper half plus the result sign bit must all agree.
  function automatic logic mul_overflow(input logic signed [2*DATA_W-1:0] p);
    return !((&p[2*DATA_W-1:DATA_W-1]) || !(|p[2*DATA_W-1:DATA_W-1]));
  endfunction

  // Returns {exception, result}; the two exceptional divides override the datapath.
  function automatic logic [DATA_W:0] div_finalize(input logic [DATA_W-1:0] q_mag,
                                                   input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    if (b == {DATA_W{1'b0}})
      return {1'b1, {DATA_W{1'b0}}};
    if ((a == INT_MIN) && (b == {DATA_W{1'b1}}))
      return {1'b1, INT_MIN};
    return {1'b0, (a[DATA_W-1] ^ b[DATA_W-1]) ? (~q_mag + 1'b1) : q_mag};
  endfunction

  state_e                    r_state;
  op_e                       r_op;
  logic [CNT_W-1:0]          r_cnt;
  logic [DATA_W-1:0]         r_result;
  logic                      r_exc;
  logic                      r_rdy;
  logic signed [DATA_W-1:0]  r_opa;
  logic signed [DATA_W-1:0]  r_opb;

  logic [DATA_W-1:0]         r_rem;
  logic [DATA_W-1:0]         r_quo;
  logic [DATA_W-1:0]         r_dvsr;
  logic [DATA_W-1:0]         w_rem_next;
  logic [DATA_W-1:0]         w_quo_next;

  logic                      w_start;
  op_e                       w_start_op;
  logic                      w_last;
  logic [2*DATA_W-1:0]       w_prod_signed;
  logic                      w_mul_exc;
  logic [DATA_W:0]           w_div_fin;

`ifdef MULTDIV_BOOTH4_EN
  logic signed [2*DATA_W-1:0] r_bacc;
  logic signed [2*DATA_W-1:0] r_bmcand;
  logic [DATA_W:0]            r_bmplier;
  logic signed [2*DATA_W-1:0] w_bpart;
  logic signed [2*DATA_W-1:0] w_bacc_next;
`else
  logic [DATA_W-1:0]          r_amag;
  logic [2*DATA_W-1:0]        r_prod;
  logic [DATA_W:0]            w_mul_sum;
  logic [2*DATA_W-1:0]        w_prod_next;
`endif

  // Start decode: MULT wins when both strobes are high.
  assign w_start    = ctrl_MULT | ctrl_DIV;
  assign w_start_op = ctrl_MULT ? OP_MULT : OP_DIV;
  assign w_last     = (r_op == OP_MULT) ? (r_cnt == MULT_LAST) : (r_cnt == DIV_LAST);

  multdiv_div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .i_rem  (r_rem),
    .i_quo  (r_quo),
    .i_dvsr (r_dvsr),
    .o_rem  (w_rem_next),
    .o_quo  (w_quo_next)
  );

`ifdef MULTDIV_BOOTH4_EN
  // Booth radix-4: recode overlapping multiplier triplets into 0, +-M, +-2M.
  always_comb begin
    w_bpart = '0;
    case (r_bmplier[2:0])
      3'b001, 3'b010: w_bpart = r_bmcand;
      3'b011:         w_bpart = r_bmcand <<< 1;
      3'b100:         w_bpart = -(r_bmcand <<< 1);
      3'b101, 3'b110: w_bpart = -r_bmcand;
      default:        w_bpart = '0;
    endcase
    w_bacc_next = r_bacc + w_bpart;
  end

  assign w_prod_signed = w_bacc_next;
`else
  // Radix-2 shift-add on magnitudes: the low half holds the unconsumed multiplier.
  assign w_mul_sum     = {1'b0, r_prod[2*DATA_W-1:DATA_W]} +
                         (r_prod[0] ? {1'b0, r_amag} : {(DATA_W+1){1'b0}});
  assign w_prod_next   = {w_mul_sum, r_prod[DATA_W-1:1]};
  assign w_prod_signed = apply_sign64(w_prod_next, r_opa[DATA_W-1] ^ r_opb[DATA_W-1]);
`endif

  assign w_mul_exc = mul_overflow(w_prod_signed);
  assign w_div_fin = div_finalize(w_quo_next, r_opa, r_opb);

  // Datapath registers: loaded on start, stepped every BUSY cycle.
  always_ff @(posedge clock) begin
    if (w_start) begin
      r_opa  <= data_operandA;
      r_opb  <= data_operandB;
      r_rem  <= '0;
      r_quo  <= magnitude(data_operandA);
      r_dvsr <= magnitude(data_operandB);
`ifdef MULTDIV_BOOTH4_EN
      r_bacc    <= '0;
      r_bmcand  <= {{DATA_W{data_operandA[DATA_W-1]}}, data_operandA};
      r_bmplier <= {data_operandB, 1'b0};
`else
      r_amag <= magnitude(data_operandA);
      r_prod <= {{DATA_W{1'b0}}, magnitude(data_operandB)};
`endif
    end else if (r_state == BUSY) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
`ifdef MULTDIV_BOOTH4_EN
      r_bacc    <= w_bacc_next;
      r_bmcand  <= r_bmcand <<< 2;
      r_bmplier <= r_bmplier >> 2;
`else
      r_prod <= w_prod_next;
`endif
    end
  end

  // Control FSM with registered outputs; result registers load on entry to DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_op     <= OP_MULT;
      r_cnt    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (w_start) begin
        r_state <= BUSY;
        r_op    <= w_start_op;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
          BUSY: begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= DONE;
              r_rdy   <= 1'b1;
              r_cnt   <= '0;
              if (r_op == OP_MULT) begin
                r_result <= w_prod_signed[DATA_W-1:0];
                r_exc    <= w_mul_exc;
              end else begin
                r_result <= w_div_fin[DATA_W-1:0];
                r_exc    <= w_div_fin[DATA_W];
              end
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv_iter.sv
// Self-checking bench for multdiv_iter: vector table, random ops against a
// behavioural model, and hand-written restart / back-to-back / reset sequences.
module tb_multdiv_iter;

`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  multdiv_iter dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic        mul;
    logic        div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
    logic [31:0] due;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[16];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // {exception, result} from plain signed arithmetic.
  function automatic logic [32:0] model(input logic m, input logic [31:0] a, input logic [31:0] b);
    int     sa, sb, q;
    longint p;
    sa = a;
    sb = b;
    if (m) begin
      p = longint'(sa) * longint'(sb);
      return {(p != longint'($signed(p[31:0]))), p[31:0]};
    end
    if (b == 32'h0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = sa / sb;
    return {1'b0, q};
  endfunction

  // Called just after a negedge: drives a one-cycle start pulse.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input logic push,
                          input logic [31:0] res, input logic exc);
    exp_t e;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    if (push) begin
      e.res = res;
      e.exc = exc;
      e.due = cyc + (m ? MUL_LAT : DIV_LAT);
      sb_q.push_back(e);
    end
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(input string name);
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (data_resultRDY) seen = 1'b1;
      else @(negedge clock);
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: no RDY seen, required one", name);
      if (sb_q.size() > 0) e = sb_q.pop_front();
    end else if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_spurious: RDY=1 with no outstanding op, required 0", name);
    end else begin
      e = sb_q.pop_front();
      check32({name, "_res"}, data_result, e.res);
      check32({name, "_exc"}, {31'b0, data_exception}, {31'b0, e.exc});
      check32({name, "_lat"}, cyc, e.due);
    end
  endtask

  task automatic expect_quiet(input string name, input int n);
    int hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (data_resultRDY) hits++;
    end
    check32({name, "_rdy_count"}, hits, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] m;
    logic [31:0] ra, rb;
    logic        rm;

    vecs[0]  = '{mul:1'b1, div:1'b0, a:32'd7,        b:32'hFFFF_FFFD, res:32'hFFFF_FFEB, exc:1'b0};
    vecs[1]  = '{mul:1'b1, div:1'b0, a:32'h0001_0000, b:32'h0001_0000, res:32'h0000_0000, exc:1'b1};
    vecs[2]  = '{mul:1'b1, div:1'b0, a:32'hFFFF_0000, b:32'h0000_8000, res:32'h8000_0000, exc:1'b0};
    vecs[3]  = '{mul:1'b0, div:1'b1, a:32'hFFFF_FF9C, b:32'd7,        res:32'hFFFF_FFF2, exc:1'b0};
    vecs[4]  = '{mul:1'b0, div:1'b1, a:32'd100,      b:32'hFFFF_FFF9, res:32'hFFFF_FFF2, exc:1'b0};
    vecs[5]  = '{mul:1'b0, div:1'b1, a:32'd5,        b:32'd0,         res:32'h0000_0000, exc:1'b1};
    vecs[6]  = '{mul:1'b0, div:1'b1, a:32'h8000_0000, b:32'hFFFF_FFFF, res:32'h8000_0000, exc:1'b1};
    vecs[7]  = '{mul:1'b1, div:1'b0, a:32'h7FFF_FFFF, b:32'd2,        res:32'hFFFF_FFFE, exc:1'b1};
    vecs[8]  = '{mul:1'b1, div:1'b0, a:32'h8000_0000, b:32'hFFFF_FFFF, res:32'h8000_0000, exc:1'b1};
    vecs[9]  = '{mul:1'b1, div:1'b0, a:32'h8000_0000, b:32'd1,        res:32'h8000_0000, exc:1'b0};
    vecs[10] = '{mul:1'b0, div:1'b1, a:32'h8000_0000, b:32'd1,        res:32'h8000_0000, exc:1'b0};
    vecs[11] = '{mul:1'b0, div:1'b1, a:32'd7,        b:32'hFFFF_FF9C, res:32'h0000_0000, exc:1'b0};
    vecs[12] = '{mul:1'b0, div:1'b1, a:32'hFFFF_FFF9, b:32'd2,        res:32'hFFFF_FFFD, exc:1'b0};
    vecs[13] = '{mul:1'b1, div:1'b0, a:32'hFFFF_FFFF, b:32'hFFFF_FFFF, res:32'h0000_0001, exc:1'b0};
    vecs[14] = '{mul:1'b1, div:1'b1, a:32'd12,       b:32'd11,        res:32'd132,       exc:1'b0};
    vecs[15] = '{mul:1'b0, div:1'b1, a:32'hFFFF_FFFF, b:32'h8000_0000, res:32'h0000_0000, exc:1'b0};

    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    check32("reset_result", data_result, 32'h0);
    check32("reset_exc", {31'b0, data_exception}, 32'h0);
    check32("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 16; i++) begin
      start_op(vecs[i].mul, vecs[i].div, vecs[i].a, vecs[i].b, 1'b1, vecs[i].res, vecs[i].exc);
      wait_rdy($sformatf("vec%0d", i));
      @(negedge clock);
      check32($sformatf("vec%0d_rdy_width", i), {31'b0, data_resultRDY}, 32'h0);
      check32($sformatf("vec%0d_hold", i), data_result, vecs[i].res);
    end

    for (int i = 0; i < 8; i++) begin
      rm = i[0];
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom_range(0, 1) ? $urandom_range(1, 5000)
                                                                          : -$urandom_range(1, 5000));
      m = model(rm, ra, rb);
      start_op(rm, ~rm, ra, rb, 1'b1, m[31:0], m[32]);
      wait_rdy($sformatf("rand%0d", i));
      @(negedge clock);
    end

    // Start issued in the DONE cycle goes straight back to BUSY.
    start_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b1, 32'd12, 1'b0);
    wait_rdy("b2b_first");
    start_op(1'b0, 1'b1, 32'd20, 32'd4, 1'b1, 32'd5, 1'b0);
    check32("b2b_rdy_low", {31'b0, data_resultRDY}, 32'h0);
    wait_rdy("b2b_second");
    @(negedge clock);

    // Restart mid-divide: only the multiply completes.
    start_op(1'b0, 1'b1, 32'd9, 32'd3, 1'b0, 32'd0, 1'b0);
    expect_quiet("restart_pre", 9);
    start_op(1'b1, 1'b0, 32'd6, 32'd7, 1'b1, 32'd42, 1'b0);
    wait_rdy("restart");
    expect_quiet("restart_after", 40);

    // Reset 20 cycles into a divide aborts it.
    start_op(1'b0, 1'b1, 32'd1000, 32'd7, 1'b0, 32'd0, 1'b0);
    expect_quiet("abort_pre", 19);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check32("abort_result", data_result, 32'h0);
    check32("abort_exc", {31'b0, data_exception}, 32'h0);
    check32("abort_rdy", {31'b0, data_resultRDY}, 32'h0);
    expect_quiet("abort_after", 40);
    start_op(1'b1, 1'b0, 32'd2, 32'd3, 1'b1, 32'd6, 1'b0);
    wait_rdy("post_reset");
    @(negedge clock);

    check32("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
